// File: rtl/frame_encoder_if.sv
// Byte-stream bus between the payload source, the frame encoder and the
// sender FIFO.
//   master : payload source / FIFO side (drives in_*, commit, out_ready)
//   slave  : frame encoder side (drives in_ready, out_*, busy, overflow)
// Signals:
//   in_data/in_valid/in_ready : payload byte handshake
//   commit                    : close current payload and send the frame
//   out_data/out_valid/out_ready : frame byte handshake toward the FIFO
//   busy                      : a frame is being emitted
//   overflow                  : one-cycle pulse, payload byte dropped
interface frame_encoder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       commit;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overflow;

    modport master (
        output in_data, in_valid, commit, out_ready,
        input  in_ready, out_data, out_valid, busy, overflow
    );

    modport slave (
        input  in_data, in_valid, commit, out_ready,
        output in_ready, out_data, out_valid, busy, overflow
    );
endinterface

// File: rtl/frame_encoder.sv
// Transmit-side framer. Buffers payload bytes, then on commit emits
// SOF, LEN, payload[0..LEN-1], CHK into the sender FIFO, where
// CHK = (LEN + sum of payload) mod 256.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : frame_encoder_if.slave (payload in, frame bytes out, status)
module frame_encoder #(
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] SOF_BYTE = 8'hAA
) (
    input  logic            clk,
    input  logic            rst_n,
    frame_encoder_if.slave  bus
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        COLLECT,
        SEND_SOF,
        SEND_LEN,
        SEND_PAY,
        SEND_CHK
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    logic [7:0]    sum;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          busy;
    logic          overflow;
    logic [7:0]    pay_buf [MAX_LEN];

    logic          in_ready;
    logic          in_xfer;
    logic          out_xfer;
    logic [CW-1:0] count_post;
    logic [CW-1:0] idx_next;

    assign in_ready   = (state == COLLECT) && (count < CW'(MAX_LEN));
    assign in_xfer    = bus.in_valid && in_ready;
    assign out_xfer   = out_valid && bus.out_ready;
    // Count as it will be after this cycle's byte, so a byte arriving
    // together with commit belongs to the frame being closed.
    assign count_post = count + CW'(in_xfer);
    assign idx_next   = idx + CW'(1);

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow;

    // Payload storage carries no reset; stale contents are never read
    // because count is cleared.
    always_ff @(posedge clk) begin
        if (in_xfer)
            pay_buf[count[AW-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            count     <= '0;
            sum       <= 8'h00;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        count <= count_post;
                        sum   <= sum + bus.in_data;
                    end else if (bus.in_valid) begin
                        // In COLLECT a refused byte can only mean a full buffer.
                        overflow <= 1'b1;
                    end
                    if (bus.commit && (count_post != '0)) begin
                        state     <= SEND_SOF;
                        out_valid <= 1'b1;
                        out_data  <= SOF_BYTE;
                        busy      <= 1'b1;
                    end
                end
                SEND_SOF: begin
                    if (out_xfer) begin
                        out_data <= 8'(count);
                        // LEN is folded into the running sum so CHK is just sum.
                        sum      <= sum + 8'(count);
                        state    <= SEND_LEN;
                    end
                end
                SEND_LEN: begin
                    if (out_xfer) begin
                        idx      <= '0;
                        out_data <= pay_buf[0];
                        state    <= SEND_PAY;
                    end
                end
                SEND_PAY: begin
                    if (out_xfer) begin
                        if (idx < count - CW'(1)) begin
                            idx      <= idx_next;
                            out_data <= pay_buf[idx_next[AW-1:0]];
                        end else begin
                            out_data <= sum;
                            state    <= SEND_CHK;
                        end
                    end
                end
                SEND_CHK: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        count     <= '0;
                        sum       <= 8'h00;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_encoder.sv
module tb_frame_encoder;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    frame_encoder_if bus ();

    frame_encoder #(.MAX_LEN(16), .SOF_BYTE(8'hAA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame built straight from the frame format rules.
    function automatic bq_t build_frame(input bq_t p);
        bq_t f;
        int  s;
        s = p.size();
        f.push_back(8'hAA);
        f.push_back(8'(p.size()));
        foreach (p[i]) begin
            f.push_back(p[i]);
            s += int'(p[i]);
        end
        f.push_back(8'(s % 256));
        return f;
    endfunction

    task automatic send_payload(input bq_t p, input bit commit_with_last);
        foreach (p[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = p[i];
            bus.commit   = commit_with_last && (i == p.size() - 1);
            chk($sformatf("in_ready_b%0d", i), {31'b0, bus.in_ready}, 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.commit   = 1'b0;
        if (!commit_with_last) begin
            bus.commit = 1'b1;
            tick();
            bus.commit = 1'b0;
        end
    endtask

    // mode 0: out_ready=1, 1: pattern 1,0,0 repeating, 2: random.
    // inject: hammer commit/in_valid while the payload is on the wire.
    task automatic recv_frame(input string name, input bq_t exp, input int mode, input bit inject);
        bq_t  got;
        int   cyc = 0;
        int   busy_cyc = 0;
        bit   prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic rdy;
        while (got.size() < exp.size() && cyc < 5000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (inject && got.size() >= 2 && got.size() < exp.size() - 1) begin
                bus.in_valid = 1'b1;
                bus.commit   = 1'b1;
                bus.in_data  = 8'($urandom);
                chk({name, "_inj_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
            end else begin
                bus.in_valid = 1'b0;
                bus.commit   = 1'b0;
            end
            chk({name, "_valid_mid"}, {31'b0, bus.out_valid}, 32'd1);
            if (bus.busy) busy_cyc++;
            if (prev_stall) chk({name, "_hold"}, {24'b0, bus.out_data}, {24'b0, prev_data});
            if (bus.out_valid && rdy) got.push_back(bus.out_data);
            prev_stall = bus.out_valid && !rdy;
            prev_data  = bus.out_data;
            tick();
            if (inject) chk({name, "_inj_overflow"}, {31'b0, bus.overflow}, 32'd0);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.commit    = 1'b0;
        bus.out_ready = 1'b1;
        chk({name, "_len"}, got.size(), exp.size());
        foreach (exp[i])
            chk($sformatf("%s_byte%0d", name, i),
                (i < got.size()) ? {24'b0, got[i]} : 32'hxxxx_xxxx, {24'b0, exp[i]});
        chk({name, "_valid_end"}, {31'b0, bus.out_valid}, 32'd0);
        chk({name, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
        chk({name, "_in_ready_end"}, {31'b0, bus.in_ready}, 32'd1);
        if (mode == 0) begin
            chk({name, "_cycles"}, cyc, exp.size());
            chk({name, "_busy_cycles"}, busy_cyc, exp.size());
        end
    endtask

    initial begin
        bq_t p;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.commit    = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, bus.out_data}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Single byte
        p = '{8'h35};
        send_payload(p, 1'b0);
        recv_frame("single", build_frame(p), 0, 1'b0);

        // Three bytes, last with commit
        p = '{8'h01, 8'h02, 8'h03};
        send_payload(p, 1'b1);
        recv_frame("three", build_frame(p), 0, 1'b0);

        // Same frame under backpressure
        send_payload(p, 1'b1);
        recv_frame("bp", build_frame(p), 1, 1'b0);

        // Commit with empty buffer is ignored
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("empty_commit_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("empty_commit_busy", {31'b0, bus.busy}, 32'd0);
        tick();
        chk("empty_commit_valid2", {31'b0, bus.out_valid}, 32'd0);

        // Full buffer, dropped byte, checksum wrap
        p = {};
        for (int i = 0; i < 16; i++) p.push_back(8'hFF);
        foreach (p[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = p[i];
            tick();
        end
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_no_ovf_yet", {31'b0, bus.overflow}, 32'd0);
        bus.in_data = 8'h12;
        tick();
        bus.in_valid = 1'b0;
        chk("ovf_pulse", {31'b0, bus.overflow}, 32'd1);
        tick();
        chk("ovf_clear", {31'b0, bus.overflow}, 32'd0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        recv_frame("full", build_frame(p), 0, 1'b0);

        // Commit and in_valid while sending payload are ignored
        p = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_payload(p, 1'b0);
        recv_frame("inject", build_frame(p), 2, 1'b1);

        // Reset in the middle of SEND_PAY
        p = '{8'h11, 8'h22, 8'h33};
        send_payload(p, 1'b0);
        tick();
        tick();
        chk("pre_rst_payload", {24'b0, bus.out_data}, 32'h11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("midrst_out_data", {24'b0, bus.out_data}, 32'd0);
        p = '{8'h7F};
        send_payload(p, 1'b0);
        recv_frame("after_rst", build_frame(p), 0, 1'b0);

        // Randomized frames against the reference model
        for (int n = 0; n < 6; n++) begin
            int len;
            len = $urandom_range(1, 16);
            p = {};
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            send_payload(p, 1'($urandom_range(0, 1)));
            recv_frame($sformatf("rand%0d", n), build_frame(p), (n % 2 == 0) ? 2 : 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_encoder.md
Name: frame_encoder

Overview:
Transmit-side framer. It is the encoding counterpart of the receive-path parser. It collects payload bytes from the sender controller into an internal buffer. On a commit pulse it emits one complete frame as a byte stream into the sender FIFO, which feeds the UART sender. Frame format: SOF, LEN, payload[0..LEN-1], CHK.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal range 1..255.
SOF_BYTE, 8'hAA, start-of-frame marker emitted first in every frame.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_data  input  8  payload byte from the source
in_valid  input  1  in_data valid this cycle
in_ready  output  1  encoder can accept a payload byte this cycle
commit  input  1  single-cycle pulse: close the current payload and transmit the frame
out_data  output  8  frame byte to the sender FIFO
out_valid  output  1  out_data holds a valid frame byte
out_ready  input  1  downstream accepts the byte (driven by ~full of the sender FIFO)
busy  output  1  a frame is being emitted
overflow  output  1  one-cycle pulse: a payload byte was dropped because the buffer is full

Behaviour:
- Reset: rst_n sampled low at a clk edge sets the following, regardless of state:
  - state=COLLECT, count=0, sum=0
  - out_valid=0, out_data=8'h00, busy=0, overflow=0
  - any partial or in-flight frame is abandoned; buffer contents are don't-care
- Counter and sum widths:
  - count is $clog2(MAX_LEN+1) bits.
  - sum is 8 bits and wraps modulo 256.
- Transfer rules:
  - An input transfer occurs on in_valid && in_ready.
  - An output transfer occurs on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data must hold stable.
- in_ready = (state==COLLECT) && (count<MAX_LEN). It is combinational from registered state.
- State COLLECT:
  - On an input transfer: buf[count] <= in_data; count++; sum <= sum + in_data.
  - If in_valid=1 and count==MAX_LEN: byte dropped, overflow=1 for the next cycle only, count and sum unchanged.
  - If commit=1 and the post-update count is 0: commit ignored, no output.
  - If commit=1 and the post-update count is ≥1: next state SEND_SOF, out_valid=1, out_data=SOF_BYTE, busy=1.
  - in_valid and commit in the same cycle: the byte is accepted (if room) and included in this frame.
  - Latency: commit at edge N gives SOF presented with out_valid=1 after edge N.
- State SEND_SOF: on an output transfer, out_data <= {zero-extend(count)} (LEN), sum <= sum + LEN, next state SEND_LEN.
- State SEND_LEN: on an output transfer, idx <= 0, out_data <= buf[0], next state SEND_PAY.
- State SEND_PAY:
  - On an output transfer with idx < count-1: idx++, out_data <= buf[idx+1].
  - On an output transfer with idx==count-1: out_data <= sum, next state SEND_CHK.
- State SEND_CHK: on an output transfer:
  - out_valid <= 0, busy <= 0
  - count <= 0, sum <= 0
  - next state COLLECT; in_ready is reasserted in the following cycle.
- Checksum: CHK = (LEN + Σ payload bytes) mod 256. SOF is excluded.
- While busy:
  - commit is ignored.
  - in_valid is not accepted: in_ready=0, no overflow pulse.
- Throughput: with out_ready held at 1, a LEN-byte frame occupies LEN+3 consecutive cycles of out_valid. There is no bubble between bytes.
- out_valid never deasserts mid-frame except by reset.

Test Plan:
- Single byte: in 0x35, then commit → out sequence AA 01 35 36; busy high for 4 cycles with out_ready=1; in_ready returns 1 after CHK.
- Three bytes 01,02,03; the third is presented in the same cycle as commit → AA 03 01 02 03 09.
- Backpressure: same frame as the previous test with out_ready toggling 1,0,0,1,… → identical byte sequence; out_data stable while out_valid&&!out_ready; no byte duplicated or skipped.
- Full buffer and wrap: 16×0xFF, then a 17th byte 0x12 → overflow pulses 1 cycle, in_ready=0. After commit: AA 10, sixteen FF, then 00 (checksum wraps mod 256).
- Ignored events:
  - commit with count=0 → out_valid stays 0.
  - commit and in_valid during SEND_PAY → frame unchanged, no overflow.
- Reset mid-frame: rst_n low during SEND_PAY → after the edge out_valid=0, busy=0, in_ready=1. The next frame of byte 0x7F gives AA 01 7F 80.
